// File: rtl/lab4_g41_p5_alu_issuer.sv
// Command issuer for a two-stage registered ALU: 8x32 register file, RAW stall, tagged writeback.
// Latency: issue edge E0 -> writeback edge E3; result/wb_valid visible the cycle after E3.
// Backpressure: cmd_ready drops on a source/in-flight-dest hazard, on ld_en and in reset. Option: LAB4_G41_ERRCNT_EN.
module lab4_g41_p5_alu_issuer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [2:0]  cmd_rd,
    input  logic [2:0]  cmd_ra,
    input  logic [2:0]  cmd_rb,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_s,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_c,
    input  logic        alu_hata,
    output logic        wb_valid,
    output logic [2:0]  wb_addr,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_c,
    output logic        flag_hata,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    typedef struct packed {
        logic       vld;
        logic [2:0] rd;
    } tag_t;

    logic [31:0] rf [8];
    tag_t [2:0]  tag;      // tag[0] = stage 1, tag[2] = stage 3 (writeback)
    tag_t        new_tag;
    logic        hazard;
    logic        issue;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (tag[i].vld && (tag[i].rd == cmd_ra || tag[i].rd == cmd_rb))
                hazard = 1'b1;
        end
    end

    assign cmd_ready   = !reset && !ld_en && !hazard;
    assign issue       = cmd_valid && cmd_ready;
    assign new_tag.vld = issue;
    assign new_tag.rd  = cmd_rd;
    assign busy        = tag[0].vld | tag[1].vld | tag[2].vld;
    assign rd_data     = rf[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
            tag       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_v    <= 1'b0;
            flag_c    <= 1'b0;
            flag_hata <= 1'b0;
        end else begin
            tag      <= {tag[1:0], new_tag};
            wb_valid <= tag[2].vld;
            if (issue) begin
                alu_a  <= rf[cmd_ra];
                alu_b  <= rf[cmd_rb];
                alu_op <= cmd_op;
            end
            if (tag[2].vld) begin
                rf[tag[2].rd] <= alu_s;
                wb_addr       <= tag[2].rd;
                flag_n        <= alu_n;
                flag_z        <= alu_z;
                flag_v        <= alu_v;
                flag_c        <= alu_c;
                flag_hata     <= alu_hata;
            end
            // Placed after the writeback so a same-index load wins the RF write.
            if (ld_en)
                rf[ld_addr] <= ld_data;
        end
    end

`ifdef LAB4_G41_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_cnt <= 8'h00;
        else if (tag[2].vld && alu_hata && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_lab4_g41_p5_alu_issuer.sv
// Directed bench for lab4_g41_p5_alu_issuer with a behavioural two-stage registered ALU.
module tb_lab4_g41_p5_alu_issuer;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_HATA = 4'd15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [2:0]  cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_s = '0;
    logic        alu_n = 1'b0, alu_z = 1'b0, alu_v = 1'b0, alu_c = 1'b0, alu_hata = 1'b0;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic        flag_n, flag_z, flag_v, flag_c, flag_hata, busy;
    logic [7:0]  err_cnt;

    int n_vec = 0;
    int n_bad = 0;

    lab4_g41_p5_alu_issuer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_s(alu_s), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .alu_hata(alu_hata),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
        .flag_hata(flag_hata), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // ALU model: operands registered, then result registered.
    logic [31:0] a_q, b_q;
    logic [3:0]  op_q;
    logic [32:0] r33;
    logic        v_nx, h_nx;

    always_comb begin
        r33  = '0;
        v_nx = 1'b0;
        h_nx = 1'b0;
        case (op_q)
            OP_ADD: begin
                r33  = {1'b0, a_q} + {1'b0, b_q};
                v_nx = (a_q[31] == b_q[31]) && (r33[31] != a_q[31]);
            end
            OP_SUB: begin
                r33  = {1'b0, a_q} - {1'b0, b_q};
                v_nx = (a_q[31] != b_q[31]) && (r33[31] != a_q[31]);
            end
            OP_HATA: h_nx = 1'b1;
            default: r33 = {1'b0, a_q & b_q};
        endcase
    end

    always @(posedge clk) begin
        a_q      <= alu_a;
        b_q      <= alu_b;
        op_q     <= alu_op;
        alu_s    <= r33[31:0];
        alu_n    <= r33[31];
        alu_z    <= (r33[31:0] == 32'd0);
        alu_c    <= r33[32];
        alu_v    <= v_nx;
        alu_hata <= h_nx;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        rd_addr = idx;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic load(input logic [2:0] idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = idx;
        ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    // Offers a command, waits (bounded) for acceptance, returns stall cycles.
    task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                        input logic [2:0] rb, output int stalls);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_ra    = ra;
        cmd_rb    = rb;
        stalls    = 0;
        #1;
        while (!cmd_ready && stalls < 20) begin
            tick();
            stalls++;
        end
        if (!cmd_ready)
            chk("send_timeout", 32'd0, 32'd1);
        else
            tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int st;
        int total;
        logic seen;
        logic [7:0] exp_err;

        // Dirty the state, then check that reset clears it.
        tick(); tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) load(3'(i), 32'hA0 + 32'(i));
        send(OP_ADD, 3'd1, 3'd2, 3'd3, st);
        tick(); tick(); tick(); tick();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        #1;
        chk("ready_in_reset", 32'(cmd_ready), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_flags", 32'({flag_n, flag_z, flag_v, flag_c, flag_hata}), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rf_chk("rst_rf", 3'(i), 32'd0);
            tick();
        end
        reset = 1'b0;
        tick();

        // Single ADD latency and busy window.
        load(3'd1, 32'd5);
        load(3'd2, 32'd7);
        send(OP_ADD, 3'd3, 3'd1, 3'd2, st);
        chk("t1_stall", 32'(st), 32'd0);
        chk("t1_alu_a", alu_a, 32'd5);
        chk("t1_alu_b", alu_b, 32'd7);
        chk("t1_alu_op", 32'(alu_op), 32'(OP_ADD));
        chk("t1_busy0", 32'(busy), 32'd1);
        tick();
        chk("t1_busy1", 32'(busy), 32'd1);
        chk("t1_no_wb1", 32'(wb_valid), 32'd0);
        tick();
        chk("t1_busy2", 32'(busy), 32'd1);
        chk("t1_no_wb2", 32'(wb_valid), 32'd0);
        tick();
        chk("t1_busy3", 32'(busy), 32'd0);
        chk("t1_wb_valid", 32'(wb_valid), 32'd1);
        chk("t1_wb_addr", 32'(wb_addr), 32'd3);
        chk("t1_flag_z", 32'(flag_z), 32'd0);
        chk("t1_flag_hata", 32'(flag_hata), 32'd0);
        rf_chk("t1_rf3", 3'd3, 32'd12);
        tick();
        chk("t1_wb_pulse", 32'(wb_valid), 32'd0);

        // Four independent commands back to back.
        for (int i = 4; i < 8; i++) begin
            send(OP_ADD, 3'(i), 3'd1, 3'd2, st);
            chk("t2_stall", 32'(st), 32'd0);
        end
        chk("t2_wb_valid", 32'(wb_valid), 32'd1);
        chk("t2_wb_addr", 32'(wb_addr), 32'd4);
        for (int i = 5; i < 8; i++) begin
            tick();
            chk("t2_wb_valid", 32'(wb_valid), 32'd1);
            chk("t2_wb_addr", 32'(wb_addr), 32'(i));
        end
        tick();
        chk("t2_wb_end", 32'(wb_valid), 32'd0);
        for (int i = 4; i < 8; i++) rf_chk("t2_rf", 3'(i), 32'd12);
        tick();

        // Read-after-write stall: second command must see 12 in RF3.
        load(3'd3, 32'd0);
        send(OP_ADD, 3'd3, 3'd1, 3'd2, st);
        send(OP_ADD, 3'd0, 3'd3, 3'd1, st);
        chk("t3_stalls", 32'(st), 32'd3);
        chk("t3_alu_a", alu_a, 32'd12);
        tick(); tick();
        chk("t3_no_wb", 32'(wb_valid), 32'd0);
        tick();
        chk("t3_wb_valid", 32'(wb_valid), 32'd1);
        chk("t3_wb_addr", 32'(wb_addr), 32'd0);
        rf_chk("t3_rf0", 3'd0, 32'd17);
        tick();

        // Load colliding with a writeback: the load owns the register.
        send(OP_ADD, 3'd4, 3'd1, 3'd2, st);
        tick(); tick();
        ld_en     = 1'b1;
        ld_addr   = 3'd4;
        ld_data   = 32'hABCD_1234;
        cmd_valid = 1'b1;
        cmd_rd    = 3'd0;
        cmd_ra    = 3'd1;
        cmd_rb    = 3'd2;
        #1;
        chk("t4_ready_ld", 32'(cmd_ready), 32'd0);
        tick();
        ld_en     = 1'b0;
        cmd_valid = 1'b0;
        chk("t4_wb_valid", 32'(wb_valid), 32'd1);
        chk("t4_wb_addr", 32'(wb_addr), 32'd4);
        chk("t4_not_issued", 32'(busy), 32'd0);
        rf_chk("t4_rf4", 3'd4, 32'hABCD_1234);
        tick();

        // Signed overflow, then a zero result.
        load(3'd1, 32'h7FFF_FFFF);
        load(3'd2, 32'd1);
        send(OP_ADD, 3'd5, 3'd1, 3'd2, st);
        tick(); tick(); tick();
        chk("t5_wb_addr", 32'(wb_addr), 32'd5);
        chk("t5_nzvc", 32'({flag_n, flag_z, flag_v, flag_c}), 32'b1010);
        rf_chk("t5_rf5", 3'd5, 32'h8000_0000);
        send(OP_SUB, 3'd6, 3'd2, 3'd2, st);
        tick(); tick(); tick();
        chk("t5_sub_nz", 32'({flag_n, flag_z}), 32'b01);
        rf_chk("t5_rf6", 3'd6, 32'd0);
        tick();

        // Reset one cycle after an issue discards the in-flight result.
        load(3'd6, 32'd0);
        send(OP_ADD, 3'd6, 3'd1, 3'd2, st);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wb_valid) seen = 1'b1;
        end
        chk("t6_no_wb", 32'(seen), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_err_cnt", 32'(err_cnt), 32'd0);
        rf_chk("t6_rf6", 3'd6, 32'd0);
        tick();

        // 300 error-producing ops.
        total = 0;
        for (int i = 0; i < 300; i++) begin
            send(OP_HATA, 3'd7, 3'd0, 3'd0, st);
            total += st;
        end
        chk("t7_stalls", 32'(total), 32'd0);
        tick(); tick(); tick();
`ifdef LAB4_G41_ERRCNT_EN
        exp_err = 8'hFF;
`else
        exp_err = 8'h00;
`endif
        chk("t7_wb_addr", 32'(wb_addr), 32'd7);
        chk("t7_flag_hata", 32'(flag_hata), 32'd1);
        chk("t7_err_cnt", 32'(err_cnt), 32'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
